// File: rtl/pipe_regs_pkg.sv
// Shared Y86-64 definitions: word width, status codes, instruction codes,
// register IDs and small control helpers used by the pipeline registers.
package y86_pkg;

  localparam int unsigned W = 64;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_e;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] FNONE = 4'h0;
  localparam logic [3:0] RNONE = 4'hF;

  // A register told to both hold and flush is a hazard-controller bug.
  function automatic logic ctrl_conflict(input logic stall, input logic bubble);
    return stall & bubble;
  endfunction

endpackage

// File: rtl/pipe_regs_if.sv
// Bundle of stage inputs, stall/bubble controls and registered stage outputs
// for the pipeline register bank.
interface pipe_regs_if #(parameter int unsigned W = 64);

  logic         F_stall, D_stall, W_stall;
  logic         D_bubble, E_bubble, M_bubble;

  logic [W-1:0] f_predPC;
  logic [1:0]   f_stat;
  logic [3:0]   f_icode, f_ifun, f_rA, f_rB;
  logic [W-1:0] f_valC, f_valP;

  logic [1:0]   d_stat;
  logic [3:0]   d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [W-1:0] d_valC, d_valA, d_valB;

  logic [1:0]   e_stat;
  logic [3:0]   e_icode;
  logic         e_Cnd;
  logic [3:0]   e_dstE, e_dstM;
  logic [W-1:0] e_valE, e_valA;

  logic [1:0]   m_stat;
  logic [3:0]   m_icode, m_dstE, m_dstM;
  logic [W-1:0] m_valE, m_valM;

  logic [W-1:0] F_predPC;

  logic [1:0]   D_stat;
  logic [3:0]   D_icode, D_ifun, D_rA, D_rB;
  logic [W-1:0] D_valC, D_valP;

  logic [1:0]   E_stat;
  logic [3:0]   E_icode, E_ifun;
  logic [W-1:0] E_valC, E_valA, E_valB;
  logic [3:0]   E_dstE, E_dstM, E_srcA, E_srcB;

  logic [1:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_Cnd;
  logic [W-1:0] M_valE, M_valA;
  logic [3:0]   M_dstE, M_dstM;

  logic [1:0]   W_stat;
  logic [3:0]   W_icode;
  logic [W-1:0] W_valE, W_valM;
  logic [3:0]   W_dstE, W_dstM;

  logic         ctrl_err;

  modport slave (
    input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
    input  f_predPC, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    input  d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB,
    input  d_valC, d_valA, d_valB,
    input  e_stat, e_icode, e_Cnd, e_dstE, e_dstM, e_valE, e_valA,
    input  m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM,
    output F_predPC,
    output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
    output E_dstE, E_dstM, E_srcA, E_srcB,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
    output ctrl_err
  );

  modport master (
    output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
    output f_predPC, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    output d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB,
    output d_valC, d_valA, d_valB,
    output e_stat, e_icode, e_Cnd, e_dstE, e_dstM, e_valE, e_valA,
    output m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM,
    input  F_predPC,
    input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
    input  E_dstE, E_dstM, E_srcA, E_srcB,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
    input  ctrl_err
  );

endinterface

// File: rtl/pipe_regs_pipe_reg.sv
// Generic pipeline register: hold on stall, load a fixed bubble pattern on
// bubble, otherwise load the next-stage value. Reset forces the bubble pattern.
module pipe_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] bubble_val,
  output logic [WIDTH-1:0] q
);

  // Stall has priority over bubble, bubble over a normal load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= bubble_val;
    else if (stall)  q <= q;
    else if (bubble) q <= bubble_val;
    else             q <= d;
  end

endmodule

// File: rtl/pipe_regs.sv
// F/D/E/M/W pipeline register bank for the five-stage Y86-64 core. Each stage
// packs its fields into one pipe_reg; missing stall/bubble controls are tied off.
module pipe_regs #(
  parameter int unsigned W = 64
) (
  input logic        clk,
  input logic        rst,
  pipe_regs_if.slave bus
);
  import y86_pkg::*;

  localparam int unsigned D_WIDTH  = 18 + 2 * W;
  localparam int unsigned E_WIDTH  = 26 + 3 * W;
  localparam int unsigned M_WIDTH  = 15 + 2 * W;
  localparam int unsigned WB_WIDTH = 14 + 2 * W;

  localparam logic [W-1:0] ZERO_W = '0;

  localparam logic [D_WIDTH-1:0] D_NOP =
    {STAT_AOK, INOP, FNONE, RNONE, RNONE, ZERO_W, ZERO_W};
  localparam logic [E_WIDTH-1:0] E_NOP =
    {STAT_AOK, INOP, FNONE, ZERO_W, ZERO_W, ZERO_W, RNONE, RNONE, RNONE, RNONE};
  localparam logic [M_WIDTH-1:0] M_NOP =
    {STAT_AOK, INOP, 1'b0, ZERO_W, ZERO_W, RNONE, RNONE};
  localparam logic [WB_WIDTH-1:0] WB_NOP =
    {STAT_AOK, INOP, ZERO_W, ZERO_W, RNONE, RNONE};

  logic [W-1:0]        f_q;
  logic [D_WIDTH-1:0]  d_next, d_q;
  logic [E_WIDTH-1:0]  e_next, e_q;
  logic [M_WIDTH-1:0]  m_next, m_q;
  logic [WB_WIDTH-1:0] w_next, w_q;
  logic                ctrl_err_q;

  assign d_next = {bus.f_stat, bus.f_icode, bus.f_ifun, bus.f_rA, bus.f_rB,
                   bus.f_valC, bus.f_valP};
  assign e_next = {bus.d_stat, bus.d_icode, bus.d_ifun, bus.d_valC, bus.d_valA,
                   bus.d_valB, bus.d_dstE, bus.d_dstM, bus.d_srcA, bus.d_srcB};
  assign m_next = {bus.e_stat, bus.e_icode, bus.e_Cnd, bus.e_valE, bus.e_valA,
                   bus.e_dstE, bus.e_dstM};
  assign w_next = {bus.m_stat, bus.m_icode, bus.m_valE, bus.m_valM,
                   bus.m_dstE, bus.m_dstM};

  pipe_reg #(.WIDTH(W)) u_f_reg (
    .clk(clk), .rst(rst), .stall(bus.F_stall), .bubble(1'b0),
    .d(bus.f_predPC), .bubble_val(ZERO_W), .q(f_q)
  );

  pipe_reg #(.WIDTH(D_WIDTH)) u_d_reg (
    .clk(clk), .rst(rst), .stall(bus.D_stall), .bubble(bus.D_bubble),
    .d(d_next), .bubble_val(D_NOP), .q(d_q)
  );

  pipe_reg #(.WIDTH(E_WIDTH)) u_e_reg (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(bus.E_bubble),
    .d(e_next), .bubble_val(E_NOP), .q(e_q)
  );

  pipe_reg #(.WIDTH(M_WIDTH)) u_m_reg (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(bus.M_bubble),
    .d(m_next), .bubble_val(M_NOP), .q(m_q)
  );

  pipe_reg #(.WIDTH(WB_WIDTH)) u_w_reg (
    .clk(clk), .rst(rst), .stall(bus.W_stall), .bubble(1'b0),
    .d(w_next), .bubble_val(WB_NOP), .q(w_q)
  );

  assign bus.F_predPC = f_q;
  assign {bus.D_stat, bus.D_icode, bus.D_ifun, bus.D_rA, bus.D_rB,
          bus.D_valC, bus.D_valP} = d_q;
  assign {bus.E_stat, bus.E_icode, bus.E_ifun, bus.E_valC, bus.E_valA,
          bus.E_valB, bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB} = e_q;
  assign {bus.M_stat, bus.M_icode, bus.M_Cnd, bus.M_valE, bus.M_valA,
          bus.M_dstE, bus.M_dstM} = m_q;
  assign {bus.W_stat, bus.W_icode, bus.W_valE, bus.W_valM,
          bus.W_dstE, bus.W_dstM} = w_q;

  // Sticky flag: D is the only register with both stall and bubble controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            ctrl_err_q <= 1'b0;
    else if (ctrl_conflict(bus.D_stall, bus.D_bubble))  ctrl_err_q <= 1'b1;
  end

  assign bus.ctrl_err = ctrl_err_q;

endmodule

// File: tb/tb_pipe_regs.sv
// Bench for pipe_regs: directed table, hand sequences for reset/halt/flow,
// then randomized traffic against an instruction-record reference model.
module tb_pipe_regs;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_regs_if #(.W(64)) bus ();
  pipe_regs #(.W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [63:0] f_predPC;
    logic [1:0]  f_stat;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic [1:0]  d_stat;
    logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
    logic [63:0] d_valC, d_valA, d_valB;
    logic [1:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_Cnd;
    logic [3:0]  e_dstE, e_dstM;
    logic [63:0] e_valE, e_valA;
    logic [1:0]  m_stat;
    logic [3:0]  m_icode, m_dstE, m_dstM;
    logic [63:0] m_valE, m_valM;
  } in_t;

  typedef struct {
    logic [1:0] stat; logic [3:0] icode, ifun, rA, rB; logic [63:0] valC, valP;
  } d_t;
  typedef struct {
    logic [1:0] stat; logic [3:0] icode, ifun; logic [63:0] valC, valA, valB;
    logic [3:0] dstE, dstM, srcA, srcB;
  } e_t;
  typedef struct {
    logic [1:0] stat; logic [3:0] icode; logic Cnd; logic [63:0] valE, valA;
    logic [3:0] dstE, dstM;
  } m_t;
  typedef struct {
    logic [1:0] stat; logic [3:0] icode; logic [63:0] valE, valM;
    logic [3:0] dstE, dstM;
  } w_t;

  // Directed table record: control bits {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall}.
  typedef struct {
    logic [5:0]  ctrl;
    logic [3:0]  fi, di, ei, mi;
    logic [63:0] pc;
    logic [63:0] xF;
    logic [3:0]  xD, xE, xM, xW;
    logic        xErr;
  } vec_t;

  in_t cur;
  logic [63:0] mF;
  d_t mD; e_t mE; m_t mM; w_t mW;
  logic mErr;

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic in_t idle_in();
    in_t t;
    t = '{default: '0};
    t.f_icode = 4'h1; t.d_icode = 4'h1; t.e_icode = 4'h1; t.m_icode = 4'h1;
    return t;
  endfunction

  function automatic in_t rand_in();
    in_t t;
    t.F_stall  = ($urandom_range(3) == 0);
    t.D_stall  = ($urandom_range(3) == 0);
    t.D_bubble = ($urandom_range(3) == 0);
    t.E_bubble = ($urandom_range(3) == 0);
    t.M_bubble = ($urandom_range(3) == 0);
    t.W_stall  = ($urandom_range(3) == 0);
    t.f_predPC = r64();
    t.f_stat = 2'($urandom); t.f_icode = 4'($urandom); t.f_ifun = 4'($urandom);
    t.f_rA = 4'($urandom); t.f_rB = 4'($urandom); t.f_valC = r64(); t.f_valP = r64();
    t.d_stat = 2'($urandom); t.d_icode = 4'($urandom); t.d_ifun = 4'($urandom);
    t.d_dstE = 4'($urandom); t.d_dstM = 4'($urandom); t.d_srcA = 4'($urandom);
    t.d_srcB = 4'($urandom); t.d_valC = r64(); t.d_valA = r64(); t.d_valB = r64();
    t.e_stat = 2'($urandom); t.e_icode = 4'($urandom); t.e_Cnd = 1'($urandom);
    t.e_dstE = 4'($urandom); t.e_dstM = 4'($urandom); t.e_valE = r64(); t.e_valA = r64();
    t.m_stat = 2'($urandom); t.m_icode = 4'($urandom); t.m_dstE = 4'($urandom);
    t.m_dstM = 4'($urandom); t.m_valE = r64(); t.m_valM = r64();
    return t;
  endfunction

  task automatic drive(input in_t t);
    bus.F_stall = t.F_stall; bus.D_stall = t.D_stall; bus.D_bubble = t.D_bubble;
    bus.E_bubble = t.E_bubble; bus.M_bubble = t.M_bubble; bus.W_stall = t.W_stall;
    bus.f_predPC = t.f_predPC;
    bus.f_stat = t.f_stat; bus.f_icode = t.f_icode; bus.f_ifun = t.f_ifun;
    bus.f_rA = t.f_rA; bus.f_rB = t.f_rB; bus.f_valC = t.f_valC; bus.f_valP = t.f_valP;
    bus.d_stat = t.d_stat; bus.d_icode = t.d_icode; bus.d_ifun = t.d_ifun;
    bus.d_dstE = t.d_dstE; bus.d_dstM = t.d_dstM; bus.d_srcA = t.d_srcA;
    bus.d_srcB = t.d_srcB; bus.d_valC = t.d_valC; bus.d_valA = t.d_valA; bus.d_valB = t.d_valB;
    bus.e_stat = t.e_stat; bus.e_icode = t.e_icode; bus.e_Cnd = t.e_Cnd;
    bus.e_dstE = t.e_dstE; bus.e_dstM = t.e_dstM; bus.e_valE = t.e_valE; bus.e_valA = t.e_valA;
    bus.m_stat = t.m_stat; bus.m_icode = t.m_icode; bus.m_dstE = t.m_dstE;
    bus.m_dstM = t.m_dstM; bus.m_valE = t.m_valE; bus.m_valM = t.m_valM;
  endtask

  // Reference model: each stage holds an instruction record; a nop is
  // AOK / icode 1 / no registers / zero data.
  task automatic model_reset();
    mF = 64'h0;
    mD = '{2'b00, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};
    mE = '{2'b00, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF};
    mM = '{2'b00, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF};
    mW = '{2'b00, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF};
    mErr = 1'b0;
  endtask

  task automatic model_edge(input in_t t);
    d_t nd; e_t ne; m_t nm; w_t nw;
    nd = '{t.f_stat, t.f_icode, t.f_ifun, t.f_rA, t.f_rB, t.f_valC, t.f_valP};
    ne = '{t.d_stat, t.d_icode, t.d_ifun, t.d_valC, t.d_valA, t.d_valB,
           t.d_dstE, t.d_dstM, t.d_srcA, t.d_srcB};
    nm = '{t.e_stat, t.e_icode, t.e_Cnd, t.e_valE, t.e_valA, t.e_dstE, t.e_dstM};
    nw = '{t.m_stat, t.m_icode, t.m_valE, t.m_valM, t.m_dstE, t.m_dstM};
    if (t.D_stall && t.D_bubble) mErr = 1'b1;
    if (!t.F_stall) mF = t.f_predPC;
    if (!t.D_stall) mD = t.D_bubble ? '{2'b00, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0} : nd;
    mE = t.E_bubble ? '{2'b00, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF} : ne;
    mM = t.M_bubble ? '{2'b00, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF} : nm;
    if (!t.W_stall) mW = nw;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("F_predPC", bus.F_predPC, mF);
    chk("D_stat", 64'(bus.D_stat), 64'(mD.stat));   chk("D_icode", 64'(bus.D_icode), 64'(mD.icode));
    chk("D_ifun", 64'(bus.D_ifun), 64'(mD.ifun));   chk("D_rA", 64'(bus.D_rA), 64'(mD.rA));
    chk("D_rB", 64'(bus.D_rB), 64'(mD.rB));         chk("D_valC", bus.D_valC, mD.valC);
    chk("D_valP", bus.D_valP, mD.valP);
    chk("E_stat", 64'(bus.E_stat), 64'(mE.stat));   chk("E_icode", 64'(bus.E_icode), 64'(mE.icode));
    chk("E_ifun", 64'(bus.E_ifun), 64'(mE.ifun));   chk("E_valC", bus.E_valC, mE.valC);
    chk("E_valA", bus.E_valA, mE.valA);             chk("E_valB", bus.E_valB, mE.valB);
    chk("E_dstE", 64'(bus.E_dstE), 64'(mE.dstE));   chk("E_dstM", 64'(bus.E_dstM), 64'(mE.dstM));
    chk("E_srcA", 64'(bus.E_srcA), 64'(mE.srcA));   chk("E_srcB", 64'(bus.E_srcB), 64'(mE.srcB));
    chk("M_stat", 64'(bus.M_stat), 64'(mM.stat));   chk("M_icode", 64'(bus.M_icode), 64'(mM.icode));
    chk("M_Cnd", 64'(bus.M_Cnd), 64'(mM.Cnd));      chk("M_valE", bus.M_valE, mM.valE);
    chk("M_valA", bus.M_valA, mM.valA);             chk("M_dstE", 64'(bus.M_dstE), 64'(mM.dstE));
    chk("M_dstM", 64'(bus.M_dstM), 64'(mM.dstM));
    chk("W_stat", 64'(bus.W_stat), 64'(mW.stat));   chk("W_icode", 64'(bus.W_icode), 64'(mW.icode));
    chk("W_valE", bus.W_valE, mW.valE);             chk("W_valM", bus.W_valM, mW.valM);
    chk("W_dstE", 64'(bus.W_dstE), 64'(mW.dstE));   chk("W_dstM", 64'(bus.W_dstM), 64'(mW.dstM));
    chk("ctrl_err", 64'(bus.ctrl_err), 64'(mErr));
  endtask

  // One clock edge with the currently driven inputs; leaves time at edge+1.
  task automatic step();
    @(posedge clk);
    if (!rst) model_edge(cur);
    #1;
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{6'b000000, 4'h3, 4'h4, 4'h5, 4'h6, 64'h100, 64'h100, 4'h3, 4'h4, 4'h5, 4'h6, 1'b0};
    tbl[1] = '{6'b000000, 4'h7, 4'h8, 4'h2, 4'hA, 64'h200, 64'h200, 4'h7, 4'h8, 4'h2, 4'hA, 1'b0};
    tbl[2] = '{6'b110100, 4'hB, 4'hC, 4'h6, 4'h5, 64'h300, 64'h200, 4'h7, 4'h1, 4'h6, 4'h5, 1'b0};
    tbl[3] = '{6'b001100, 4'h3, 4'h4, 4'h7, 4'h2, 64'h400, 64'h400, 4'h1, 4'h1, 4'h7, 4'h2, 1'b0};
    tbl[4] = '{6'b000001, 4'h2, 4'h3, 4'h4, 4'h0, 64'h500, 64'h500, 4'h2, 4'h3, 4'h4, 4'h2, 1'b0};
    tbl[5] = '{6'b000010, 4'h5, 4'h6, 4'h8, 4'h9, 64'h600, 64'h600, 4'h5, 4'h6, 4'h1, 4'h9, 1'b0};
    tbl[6] = '{6'b011000, 4'hA, 4'hB, 4'hC, 4'hD, 64'h700, 64'h700, 4'h5, 4'hB, 4'hC, 4'hD, 1'b1};
    tbl[7] = '{6'b000000, 4'h3, 4'h3, 4'h3, 4'h3, 64'h800, 64'h800, 4'h3, 4'h3, 4'h3, 4'h3, 1'b1};

    cur = idle_in();
    drive(cur);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_E_icode", 64'(bus.E_icode), 64'h1);
    rst = 1'b0;

    // Directed control combinations; mispredict entry carries jXX with Cnd=0.
    for (int i = 0; i < 8; i++) begin
      cur = idle_in();
      {cur.F_stall, cur.D_stall, cur.D_bubble, cur.E_bubble, cur.M_bubble, cur.W_stall} = tbl[i].ctrl;
      cur.f_icode = tbl[i].fi; cur.d_icode = tbl[i].di;
      cur.e_icode = tbl[i].ei; cur.m_icode = tbl[i].mi;
      cur.f_predPC = tbl[i].pc; cur.e_Cnd = 1'b0; cur.e_dstM = 4'h3;
      drive(cur);
      step();
      check_all();
      chk($sformatf("tbl%0d_F", i), bus.F_predPC, tbl[i].xF);
      chk($sformatf("tbl%0d_D", i), 64'(bus.D_icode), 64'(tbl[i].xD));
      chk($sformatf("tbl%0d_E", i), 64'(bus.E_icode), 64'(tbl[i].xE));
      chk($sformatf("tbl%0d_M", i), 64'(bus.M_icode), 64'(tbl[i].xM));
      chk($sformatf("tbl%0d_W", i), 64'(bus.W_icode), 64'(tbl[i].xW));
      chk($sformatf("tbl%0d_err", i), 64'(bus.ctrl_err), 64'(tbl[i].xErr));
    end
    chk("loaduse_Cnd_after_misp", 64'(bus.M_Cnd), 64'h0);

    // Asynchronous reset mid-cycle, with no clock edge in between.
    cur = rand_in();
    drive(cur);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_F_predPC", bus.F_predPC, 64'h0);
    chk("async_E_icode", 64'(bus.E_icode), 64'h1);
    chk("async_E_dstE", 64'(bus.E_dstE), 64'hF);
    chk("async_ctrl_err", 64'(bus.ctrl_err), 64'h0);
    check_all();
    step();
    check_all();
    #2 rst = 1'b0;

    // Straight flow: irmovq into D, d_ values into E.
    cur = idle_in();
    cur.f_icode = 4'h3; cur.f_valC = 64'h10; cur.d_icode = 4'h6; cur.d_valA = 64'h55;
    drive(cur);
    step();
    chk("flow_D_icode", 64'(bus.D_icode), 64'h3);
    chk("flow_D_valC", bus.D_valC, 64'h10);
    chk("flow_E_valA", bus.E_valA, 64'h55);
    check_all();

    // Halt: W holds while the other stages keep loading.
    cur = idle_in();
    cur.m_stat = 2'b00; cur.m_valE = 64'h1234;
    drive(cur);
    step();
    chk("halt_pre_W_valE", bus.W_valE, 64'h1234);
    for (int i = 0; i < 3; i++) begin
      cur = idle_in();
      cur.W_stall = 1'b1; cur.m_stat = 2'b01; cur.m_valE = 64'hDEAD;
      cur.f_icode = 4'(i + 2);
      drive(cur);
      step();
      chk("halt_W_stat", 64'(bus.W_stat), 64'h0);
      chk("halt_W_valE", bus.W_valE, 64'h1234);
      chk("halt_D_icode", 64'(bus.D_icode), 64'(i + 2));
      check_all();
    end

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 400; n++) begin
      cur = rand_in();
      drive(cur);
      step();
      check_all();
      if ($urandom_range(39) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #1 rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
